// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited in-order memory requests, prefetch FIFO
// and a registered instruction output to decode, with stall and redirect flush.
module fetch_unit #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic [XLEN-1:0] Instruction,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_valid
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  logic [XLEN-1:0] r_fetch_pc;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_discard;
  logic [CW-1:0]   r_count;
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW-1:0]   r_pq_wr;
  logic [AW-1:0]   r_pq_rd;
  logic [XLEN-1:0] r_fifo_data [FIFO_DEPTH];
  logic [XLEN-1:0] r_fifo_pc   [FIFO_DEPTH];
  logic [XLEN-1:0] r_pq        [FIFO_DEPTH];
  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_inst_pc;
  logic            r_inst_valid;

  logic [CW:0]     w_inflight;
  logic            w_credit;
  logic            w_req_fire;
  logic            w_drop;
  logic            w_push;
  logic            w_pop;
  logic [CW-1:0]   w_rsp_dec;

  // Every accepted request owns a FIFO slot, so the FIFO can never overflow.
  assign w_inflight     = {1'b0, r_outstanding} + {1'b0, r_count};
  assign w_credit       = w_inflight < (CW+1)'(FIFO_DEPTH);
  assign imem_req_valid = !rst && !redirect_valid && w_credit;
  assign imem_req_addr  = r_fetch_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;
  assign w_drop         = imem_rsp_valid && (r_discard != '0);
  assign w_push         = imem_rsp_valid && (r_discard == '0) && !redirect_valid;
  assign w_pop          = !stall && (r_count != '0) && !redirect_valid;
  assign w_rsp_dec      = CW'(imem_rsp_valid);

  assign Instruction = r_instr;
  assign inst_pc     = r_inst_pc;
  assign inst_valid  = r_inst_valid;

  // Storage arrays carry no reset; occupancy is tracked by the control state.
  always_ff @(posedge clk) begin
    if (w_req_fire) r_pq[r_pq_wr] <= r_fetch_pc;
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= imem_rsp_data;
      r_fifo_pc[r_wr_ptr]   <= r_pq[r_pq_rd];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_count       <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_pq_wr       <= '0;
      r_pq_rd       <= '0;
      r_instr       <= NOP;
      r_inst_pc     <= '0;
      r_inst_valid  <= 1'b0;
    end else if (redirect_valid) begin
      // Responses still in flight after this cycle belong to the wrong path.
      r_fetch_pc    <= redirect_pc & ~XLEN'(3);
      r_outstanding <= r_outstanding - w_rsp_dec;
      r_discard     <= r_outstanding - w_rsp_dec;
      r_count       <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_pq_wr       <= '0;
      r_pq_rd       <= '0;
      r_instr       <= NOP;
      r_inst_valid  <= 1'b0;
    end else begin
      if (w_req_fire) begin
        r_fetch_pc <= r_fetch_pc + XLEN'(4);
        r_pq_wr    <= r_pq_wr + AW'(1);
      end
      r_outstanding <= r_outstanding + CW'(w_req_fire) - w_rsp_dec;
      if (w_drop) r_discard <= r_discard - CW'(1);
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
        r_pq_rd  <= r_pq_rd + AW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      if (!stall) begin
        if (r_count != '0) begin
          r_instr      <= r_fifo_data[r_rd_ptr];
          r_inst_pc    <= r_fifo_pc[r_rd_ptr];
          r_inst_valid <= 1'b1;
          r_rd_ptr     <= r_rd_ptr + AW'(1);
        end else begin
          r_instr      <= NOP;
          r_inst_valid <= 1'b0;
        end
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(w_push && (r_count == CW'(FIFO_DEPTH))));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(w_pop && (r_count == '0)));
  a_rsp_expected: assert property (@(posedge clk) disable iff (rst)
    !(imem_rsp_valid && (r_outstanding == '0)));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model returning address as data, and a
// scoreboard of expected PCs filled at request time and drained at the output.
module tb_fetch_unit;
  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        stall = 1'b0;
  logic [31:0] Instruction;
  logic [31:0] inst_pc;
  logic        inst_valid;

  always #5 clk = ~clk;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall(stall),
    .Instruction(Instruction), .inst_pc(inst_pc), .inst_valid(inst_valid)
  );

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          mq_due[$];
  logic [31:0] mq_addr[$];
  int          last_due = -1;
  logic [31:0] sb[$];
  logic [31:0] fire_log[$];
  logic [31:0] next_addr = 32'h0;
  int          lat = 1;
  bit          rand_ready = 0;
  bit          rand_lat = 0;
  bit          prev_skip = 1, prev_rst = 0, prev_stall = 0, prev_redir = 0;
  logic [31:0] prev_instr, prev_pc;
  logic        prev_valid;
  bit          got_new = 0;
  logic [31:0] last_pc = '0;
  int          first_fire_cyc = -1;
  int          first_valid_cyc = -1;

  // One clock cycle: memory model, output scoreboard, request tracking.
  task automatic step();
    int sz;
    int due;
    @(negedge clk);
    if (rand_ready) imem_req_ready = ($urandom_range(0, 1) == 1);
    if (rst) begin
      mq_due.delete(); mq_addr.delete(); last_due = -1;
    end
    sz = mq_due.size();
    if (sz > 0 && mq_due[0] == cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mq_addr[0];
      void'(mq_due.pop_front());
      void'(mq_addr.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'hDEAD_BEEF;
    end
    #1;
    got_new = 0;
    if (!prev_skip) begin
      if (prev_rst || prev_redir) begin
        n_checks++;
        if (inst_valid !== 1'b0 || Instruction !== NOP) begin
          n_fail++;
          $display("FAIL flush_out cyc=%0d: valid=%b instr=%h, expected valid=0 instr=%h", cyc, inst_valid, Instruction, NOP);
        end
        if (prev_rst) begin
          n_checks++;
          if (inst_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_pc cyc=%0d: inst_pc=%h expected 0", cyc, inst_pc);
          end
        end
      end else if (prev_stall) begin
        n_checks++;
        if (Instruction !== prev_instr || inst_pc !== prev_pc || inst_valid !== prev_valid) begin
          n_fail++;
          $display("FAIL stall_hold cyc=%0d: got %h/%h/%b expected %h/%h/%b", cyc, Instruction, inst_pc, inst_valid, prev_instr, prev_pc, prev_valid);
        end
      end else if (inst_valid === 1'b1) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_inst cyc=%0d: pc=%h, expected no instruction", cyc, inst_pc);
        end else begin
          if (inst_pc !== sb[0] || Instruction !== sb[0]) begin
            n_fail++;
            $display("FAIL order cyc=%0d: pc=%h instr=%h expected %h", cyc, inst_pc, Instruction, sb[0]);
          end
          void'(sb.pop_front());
        end
        got_new = 1;
        last_pc = inst_pc;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end else begin
        n_checks++;
        if (inst_valid !== 1'b0 || Instruction !== NOP) begin
          n_fail++;
          $display("FAIL idle_nop cyc=%0d: valid=%b instr=%h expected 0/%h", cyc, inst_valid, Instruction, NOP);
        end
      end
    end
    if (rst || redirect_valid) begin
      n_checks++;
      if (imem_req_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL req_blocked cyc=%0d: req_valid=%b expected 0", cyc, imem_req_valid);
      end
    end
    if (!rst) begin
      n_checks++;
      if (sz > DEPTH) begin
        n_fail++;
        $display("FAIL outstanding cyc=%0d: %0d in flight, limit %0d", cyc, sz, DEPTH);
      end
    end
    if (imem_req_valid === 1'b1 && imem_req_ready) begin
      n_checks++;
      if (imem_req_addr !== next_addr) begin
        n_fail++;
        $display("FAIL addr_seq cyc=%0d: addr=%h expected %h", cyc, imem_req_addr, next_addr);
      end
      due = cyc + (rand_lat ? int'($urandom_range(1, 4)) : lat);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mq_due.push_back(due);
      mq_addr.push_back(imem_req_addr);
      sb.push_back(next_addr);
      fire_log.push_back(imem_req_addr);
      next_addr = next_addr + 32'd4;
      if (first_fire_cyc < 0) first_fire_cyc = cyc;
    end
    if (redirect_valid && !rst) begin
      sb.delete();
      next_addr = redirect_pc & ~32'h3;
    end
    if (rst) begin
      sb.delete();
      next_addr = 32'h0;
    end
    prev_skip = 0; prev_rst = rst; prev_stall = stall; prev_redir = redirect_valid;
    prev_instr = Instruction; prev_pc = inst_pc; prev_valid = inst_valid;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    n_checks++;
    if (imem_req_valid !== 1'b0 || imem_req_addr !== 32'h0 || inst_valid !== 1'b0 ||
        Instruction !== NOP || inst_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state: req_valid=%b addr=%h valid=%b instr=%h pc=%h expected 0/0/0/%h/0",
               imem_req_valid, imem_req_addr, inst_valid, Instruction, inst_pc, NOP);
    end
  endtask

  task automatic test_stream();
    first_fire_cyc = -1; first_valid_cyc = -1;
    rst = 1'b0; imem_req_ready = 1'b1; lat = 1;
    repeat (12) step();
    n_checks++;
    if (first_fire_cyc < 0 || first_valid_cyc - first_fire_cyc != 3) begin
      n_fail++;
      $display("FAIL first_latency: %0d cycles from first request to inst_valid, expected 3", first_valid_cyc - first_fire_cyc);
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    repeat (6) step();
    n_checks++;
    if (imem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL credit_full: req_valid=%b expected 0 after stall fills FIFO", imem_req_valid);
    end
    stall = 1'b0;
    repeat (10) step();
  endtask

  task automatic test_redirect_inflight();
    int k;
    rst = 1'b1; step(); rst = 1'b0;
    imem_req_ready = 1'b1; lat = 3;
    step(); step();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    step();
    redirect_valid = 1'b0;
    k = 0;
    do begin step(); k++; end while (!got_new && k < 20);
    n_checks++;
    if (!got_new || last_pc !== 32'h100) begin
      n_fail++;
      $display("FAIL redirect_first: pc=%h (seen=%0d) expected 00000100", last_pc, got_new);
    end
    k = 0;
    do begin step(); k++; end while (!got_new && k < 20);
    n_checks++;
    if (!got_new || last_pc !== 32'h104) begin
      n_fail++;
      $display("FAIL redirect_second: pc=%h (seen=%0d) expected 00000104", last_pc, got_new);
    end
    repeat (6) step();
  endtask

  task automatic test_redirect_stall();
    int idx;
    lat = 1; imem_req_ready = 1'b1;
    repeat (4) step();
    stall = 1'b1;
    step(); step();
    idx = fire_log.size();
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    step();
    redirect_valid = 1'b0;
    step();
    n_checks++;
    if (inst_valid !== 1'b0 || Instruction !== NOP) begin
      n_fail++;
      $display("FAIL redir_stall_out: valid=%b instr=%h expected 0/%h", inst_valid, Instruction, NOP);
    end
    repeat (3) step();
    n_checks++;
    if (fire_log.size() <= idx || fire_log[idx] !== 32'h200) begin
      n_fail++;
      $display("FAIL redir_stall_addr: first fetch after redirect %h expected 00000200",
               (fire_log.size() > idx) ? fire_log[idx] : 32'hFFFF_FFFF);
    end
    stall = 1'b0;
    repeat (10) step();
  endtask

  task automatic test_wrap();
    int idx;
    logic [31:0] exp_a [3];
    exp_a[0] = 32'hFFFF_FFF8; exp_a[1] = 32'hFFFF_FFFC; exp_a[2] = 32'h0000_0000;
    idx = fire_log.size();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFB;
    step();
    redirect_valid = 1'b0;
    repeat (8) step();
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (fire_log.size() <= idx + i || fire_log[idx + i] !== exp_a[i]) begin
        n_fail++;
        $display("FAIL wrap_addr%0d: got %h expected %h", i,
                 (fire_log.size() > idx + i) ? fire_log[idx + i] : 32'hBAD0_BAD0, exp_a[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    lat = 2; imem_req_ready = 1'b1;
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if (imem_req_addr !== 32'h0 || inst_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: addr=%h valid=%b expected 0/0", imem_req_addr, inst_valid);
    end
    repeat (10) step();
  endtask

  task automatic test_random();
    rand_ready = 1; rand_lat = 1;
    for (int i = 0; i < 400; i++) begin
      stall = ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 39) == 0);
      redirect_pc = $urandom;
      step();
    end
    redirect_valid = 1'b0; stall = 1'b0;
  endtask

  task automatic test_drain();
    rand_ready = 0; rand_lat = 0; imem_req_ready = 1'b0;
    repeat (20) step();
    n_checks++;
    if (sb.size() != 0 || inst_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain: %0d instructions undelivered, valid=%b, expected 0/0", sb.size(), inst_valid);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_inflight();
    test_redirect_stall();
    test_wrap();
    test_reset_mid();
    test_random();
    test_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage sitting directly upstream of the decode stage; its registered outputs drive decode's `Instruction` input.
- Holds the fetch PC and issues in-order word requests to instruction memory over a valid/ready channel.
- Buffers returned words in a small prefetch FIFO and presents one instruction per cycle to decode.
- Honours a decode/hazard stall and flushes on a branch/jump redirect, discarding wrong-path responses still in flight.

Parameters:
- XLEN, 32, data and address width.
- RESET_PC, 32'h0000_0000, fetch address loaded at reset.
- FIFO_DEPTH, 4, prefetch entries. Must be a power of 2 and ≥2; 4 sustains 1 instr/cycle at 1-cycle memory latency.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  word-aligned fetch address (= fetch_pc).
- imem_rsp_valid  in  1  response valid; in order, ≥1 cycle after acceptance, never back-pressured.
- imem_rsp_data  in  XLEN  instruction word.
- redirect_valid  in  1  branch/jump taken; flush and refetch.
- redirect_pc  in  XLEN  redirect target.
- stall  in  1  decode cannot accept a new instruction this cycle.
- Instruction  out  XLEN  registered instruction to decode.
- inst_pc  out  XLEN  PC of Instruction.
- inst_valid  out  1  Instruction is a real fetched instruction.

Behaviour:
- Reset values: fetch_pc=RESET_PC, outstanding=0, discard=0, FIFO empty, Instruction=32'h0000_0013 (NOP), inst_pc=0, inst_valid=0. imem_req_valid is 0 during the rst cycle.
- Memory shares rst, so no responses arrive from before reset. Reset mid-operation drops all FIFO and in-flight state.
- Credit rule: imem_req_valid = !rst && !redirect_valid && (outstanding + fifo_count < FIFO_DEPTH). Counters are $clog2(FIFO_DEPTH)+1 bits.
- Request handshake (valid && ready): outstanding+1 and fetch_pc+4, wrapping modulo 2^XLEN (0xFFFF_FFFC → 0x0000_0000).
- Response: outstanding−1.
  - If discard>0: discard−1 and the word is dropped.
  - Otherwise push {data, pc} into the FIFO. The PC tag comes from a parallel pc queue written at request time.
  - Request and response in the same cycle: outstanding unchanged.
- Output register:
  - When !stall and FIFO non-empty: pop head into Instruction/inst_pc and set inst_valid=1.
  - When !stall and FIFO empty: inst_valid=0 and Instruction=NOP.
  - When stall: all three outputs hold their values.
- Latency: response in cycle t → FIFO at edge end of t → visible on Instruction in cycle t+2 (no bypass).
- Redirect (highest priority, overrides stall):
  - fetch_pc ← {redirect_pc[XLEN-1:2], 2'b00}; bits [1:0] are forced to 0.
  - FIFO and pc queue are flushed.
  - discard ← outstanding − (imem_rsp_valid ? 1 : 0), i.e. all in-flight responses not consumed this cycle.
  - Outputs ← NOP, inst_valid=0.
  - No request is issued in the redirect cycle; fetch resumes the next cycle.
- Back-to-back redirects: each recomputes discard from current outstanding. Correctness follows from in-order responses.
- FIFO never overflows by the credit rule. Any push to a full FIFO or pop from an empty one is a design error; assertions flag both.

Test Plan:
- Reset then rst=0, ready=1, 1-cycle latency, memory returns addr as data → requests 0x0,0x4,0x8…; inst_valid first high 3 cycles after first request, then one instr/cycle with inst_pc=Instruction.
- Stream with stall=1 for 6 cycles → Instruction/inst_pc held; imem_req_valid drops once 4 credits are used; on release, instructions continue in order with no loss or duplication.
- Redirect to 0x100 with 2 requests in flight (3-cycle latency) → both stale responses discarded; next inst_valid shows inst_pc=0x100, then 0x104.
- redirect_valid and stall both high → outputs become NOP with inst_valid=0, FIFO flushed, next fetch addr=redirect target.
- Redirect to 0xFFFF_FFFB → fetch 0xFFFF_FFF8, 0xFFFF_FFFC, then 0x0000_0000.
- imem_req_ready toggling randomly with latency 1–4 → address sequence contiguous, outstanding ≤4, and output order matches request order.
